cw_winnow: RTL and testbench

- Receive-side winnowing stage, directly downstream of the chaffing stage (cw).
- Consumes the serialized chaffed packet stream, one {bit, tag, ctr} packet per handshake, in pair order 2j (genuine or chaff), 2j+1 (complement).
- Keeps the bit whose tag equals the expected MAC for position j and rebuilds the cwbits-bit message.
- Checks counter consistency and freshness, then presents the message with error flags on a valid/ready output.

---
 rtl/cw_pkg.sv | 42 ++++
 rtl/cw_pair_select.sv | 31 +++
 rtl/cw_winnow.sv | 212 +++++++++++++++++++++
 tb/tb_cw_winnow.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cw_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cw_pkg
// Purpose  : Shared packet layout, error indices and state encoding for the
//            chaffing (cw) and winnowing (cw_winnow) stages.
// Revision : 1.0 - initial release
// ============================================================================
package cw_pkg;

    // Counter field occupies the least significant bits of a packet.
    localparam int CTR_LSB = 0;

    // Error flag positions inside msg_err.
    localparam int TAG_ERR = 0;
    localparam int CTR_ERR = 1;
    localparam int SEQ_ERR = 2;
    localparam int ERR_W   = 3;

    // Two-state receive controller.
    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_t;

    // Packet width: {bit, tag, ctr}.
    function automatic int pkt_width(input int ctrsize, input int tagsize);
        return ctrsize + tagsize + 1;
    endfunction

    // Lowest bit of the tag field.
    function automatic int tag_lsb(input int ctrsize);
        return CTR_LSB + ctrsize;
    endfunction

    // Position of the payload bit (packet MSB).
    function automatic int bit_pos(input int ctrsize, input int tagsize);
        return CTR_LSB + ctrsize + tagsize;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cw_pair_select.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cw_pair_select
// Purpose  : Picks the genuine bit out of a chaffed pair. The even packet is
//            presented already reduced to its bit and tag-match flag; the odd
//            packet is compared here against the expected tag.
// Revision : 1.0 - initial release
// ============================================================================
module cw_pair_select #(
    parameter int TAGSIZE = 16
) (
    input  logic               i_even_bit,
    input  logic               i_even_match,
    input  logic               i_odd_bit,
    input  logic [TAGSIZE-1:0] i_odd_tag,
    input  logic [TAGSIZE-1:0] i_exp_tag,
    output logic               o_sel_bit,
    output logic               o_ambig
);

    logic w_odd_match;

    assign w_odd_match = (i_odd_tag == i_exp_tag);

    // Zero or two matches cannot identify the genuine packet.
    assign o_ambig   = (i_even_match == w_odd_match);
    assign o_sel_bit = o_ambig ? 1'b0 : (i_even_match ? i_even_bit : i_odd_bit);

endmodule
`default_nettype wire

// File: rtl/cw_winnow.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cw_winnow
// Purpose  : Receive-side winnowing. Rebuilds a CWBITS message from the
//            chaffed {bit, tag, ctr} packet stream, checks counter
//            consistency and freshness, and presents the result on a
//            valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module cw_winnow
    import cw_pkg::*;
#(
    parameter int CWBITS    = 32,
    parameter int CTRSIZE   = 16,
    parameter int TAGSIZE   = 16,
    parameter int CACHESIZE = 64
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [CACHESIZE*TAGSIZE-1:0]          maccache,
    input  logic                                  pkt_valid,
    output logic                                  pkt_ready,
    input  logic                                  pkt_sof,
    input  logic [pkt_width(CTRSIZE,TAGSIZE)-1:0] pkt_data,
    output logic                                  msg_valid,
    input  logic                                  msg_ready,
    output logic [CWBITS-1:0]                     msg_out,
    output logic [CTRSIZE-1:0]                    msg_ctr,
    output logic [ERR_W-1:0]                      msg_err,
    output logic [7:0]                            resync_cnt
);

    localparam int c_BIT_POS  = bit_pos(CTRSIZE, TAGSIZE);
    localparam int c_TAG_LSB  = tag_lsb(CTRSIZE);
    localparam int c_IDX_W    = $clog2(2 * CWBITS);
    localparam int c_J_W      = $clog2(CACHESIZE);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(2 * CWBITS - 1);

    generate
        if (CWBITS % 2 != 0) begin : g_bad_cwbits
            $error("cw_winnow: CWBITS must be even");
        end
        if (CACHESIZE < CWBITS) begin : g_bad_cache
            $error("cw_winnow: CACHESIZE must be >= CWBITS");
        end
    endgenerate

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_IDX_W-1:0]    r_pkt_idx;
    logic                  r_even_bit;
    logic                  r_even_match;
    logic [CTRSIZE-1:0]    r_frame_ctr;
    logic [CTRSIZE-1:0]    r_last_ctr;
    logic                  r_have_last;
    logic [CWBITS-1:0]     r_msg;
    logic                  r_tag_err;
    logic                  r_ctr_err;
    logic                  r_seq_err;
    logic [7:0]            r_resync_cnt;

    logic [TAGSIZE-1:0]    w_cache [CACHESIZE];
    logic                  w_collect;
    logic                  w_accept;
    logic                  w_bit;
    logic [TAGSIZE-1:0]    w_tag;
    logic [CTRSIZE-1:0]    w_ctr;
    logic [c_IDX_W-1:0]    w_idx;
    logic [c_IDX_W-2:0]    w_pair;
    logic [TAGSIZE-1:0]    w_exp_tag;
    logic                  w_sel_bit;
    logic                  w_ambig;
    logic                  w_ctr_mis;
    logic                  w_last;
    logic                  w_seq_err;
    logic                  w_frame_clean;

    for (genvar gi = 0; gi < CACHESIZE; gi++) begin : g_cache
        assign w_cache[gi] = maccache[gi*TAGSIZE +: TAGSIZE];
    end

    assign w_bit     = pkt_data[c_BIT_POS];
    assign w_tag     = pkt_data[c_TAG_LSB +: TAGSIZE];
    assign w_ctr     = pkt_data[CTR_LSB +: CTRSIZE];

    // A start-of-frame packet is always treated as index 0, whatever came before.
    assign w_idx     = pkt_sof ? '0 : r_pkt_idx;
    assign w_pair    = w_idx[c_IDX_W-1:1];
    assign w_exp_tag = w_cache[c_J_W'(w_pair)];

    assign w_collect = (r_state == COLLECT);
    assign w_accept  = pkt_valid && w_collect;
    assign w_ctr_mis = (w_ctr != r_frame_ctr);
    assign w_last    = w_accept && !pkt_sof && (r_pkt_idx == c_LAST_IDX);

    // Freshness: frame counter must be exactly one past the last clean frame.
    assign w_seq_err     = r_have_last && (r_frame_ctr != (r_last_ctr + CTRSIZE'(1)));
    assign w_frame_clean = !(r_tag_err || w_ambig) && !(r_ctr_err || w_ctr_mis);

    cw_pair_select #(
        .TAGSIZE     (TAGSIZE)
    ) u_pair_select (
        .i_even_bit  (r_even_bit),
        .i_even_match(r_even_match),
        .i_odd_bit   (w_bit),
        .i_odd_tag   (w_tag),
        .i_exp_tag   (w_exp_tag),
        .o_sel_bit   (w_sel_bit),
        .o_ambig     (w_ambig)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        pkt_ready   = 1'b0;
        msg_valid   = 1'b0;
        case (r_state)
            COLLECT: begin
                pkt_ready = 1'b1;
                if (w_last) begin
                    w_state_nxt = OUTPUT;
                end
            end
            OUTPUT: begin
                msg_valid = 1'b1;
                if (msg_ready) begin
                    w_state_nxt = COLLECT;
                end
            end
            default: w_state_nxt = COLLECT;
        endcase
    end

    // Packet collection, pair decoding, error tracking and frame bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_idx    <= '0;
            r_even_bit   <= 1'b0;
            r_even_match <= 1'b0;
            r_frame_ctr  <= '0;
            r_last_ctr   <= '0;
            r_have_last  <= 1'b0;
            r_msg        <= '0;
            r_tag_err    <= 1'b0;
            r_ctr_err    <= 1'b0;
            r_seq_err    <= 1'b0;
            r_resync_cnt <= '0;
        end else if (!w_collect) begin
            if (msg_ready) begin
                r_pkt_idx <= '0;
                r_tag_err <= 1'b0;
                r_ctr_err <= 1'b0;
                r_seq_err <= 1'b0;
            end
        end else if (w_accept) begin
            if (pkt_sof) begin
                if ((r_pkt_idx != '0) && (r_resync_cnt != 8'hFF)) begin
                    r_resync_cnt <= r_resync_cnt + 8'd1;
                end
                r_frame_ctr  <= w_ctr;
                r_even_bit   <= w_bit;
                r_even_match <= (w_tag == w_exp_tag);
                r_tag_err    <= 1'b0;
                r_ctr_err    <= 1'b0;
                r_seq_err    <= 1'b0;
                r_pkt_idx    <= c_IDX_W'(1);
            end else if (r_pkt_idx != '0) begin
                if (w_ctr_mis) begin
                    r_ctr_err <= 1'b1;
                end
                if (!r_pkt_idx[0]) begin
                    r_even_bit   <= w_bit;
                    r_even_match <= (w_tag == w_exp_tag);
                    r_pkt_idx    <= r_pkt_idx + c_IDX_W'(1);
                end else begin
                    r_msg[w_pair] <= w_sel_bit;
                    if (w_ambig) begin
                        r_tag_err <= 1'b1;
                    end
                    if (r_pkt_idx == c_LAST_IDX) begin
                        r_seq_err <= w_seq_err;
                        if (w_frame_clean) begin
                            r_last_ctr  <= r_frame_ctr;
                            r_have_last <= 1'b1;
                        end
                    end else begin
                        r_pkt_idx <= r_pkt_idx + c_IDX_W'(1);
                    end
                end
            end
        end
    end

    assign msg_out          = r_msg;
    assign msg_ctr          = r_frame_ctr;
    assign msg_err[TAG_ERR] = r_tag_err;
    assign msg_err[CTR_ERR] = r_ctr_err;
    assign msg_err[SEQ_ERR] = r_seq_err;
    assign resync_cnt       = r_resync_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cw_winnow.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cw_winnow
// Purpose  : Self-checking bench for cw_winnow with a frame-level reference
//            model of the chaffer and the winnower.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cw_winnow;

    logic              clk = 1'b0;
    logic              rst;
    logic [64*16-1:0]  maccache;
    logic              pkt_valid;
    logic              pkt_ready;
    logic              pkt_sof;
    logic [32:0]       pkt_data;
    logic              msg_valid;
    logic              msg_ready;
    logic [31:0]       msg_out;
    logic [15:0]       msg_ctr;
    logic [2:0]        msg_err;
    logic [7:0]        resync_cnt;

    logic [15:0]       cache  [0:63];
    logic [32:0]       f_data [0:63];

    int                n_cmp  = 0;
    int                n_fail = 0;
    logic              m_have_last;
    logic [15:0]       m_last_ctr;
    int                m_resync;

    cw_winnow dut (
        .clk        (clk),
        .rst        (rst),
        .maccache   (maccache),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .pkt_sof    (pkt_sof),
        .pkt_data   (pkt_data),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .msg_out    (msg_out),
        .msg_ctr    (msg_ctr),
        .msg_err    (msg_err),
        .resync_cnt (resync_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 64; i++) maccache[i*16 +: 16] = cache[i];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Chaffer model: genuine packet carries the cached tag, chaff carries the
    // complemented bit and any other tag; order within a pair is random.
    task automatic build_frame(input logic [31:0] m, input logic [15:0] c);
        logic [15:0] t;
        logic [32:0] gen, chf;
        for (int j = 0; j < 32; j++) begin
            do t = 16'($urandom); while (t == cache[j]);
            gen = {m[j], cache[j], c};
            chf = {~m[j], t, c};
            if ($urandom_range(0, 1) == 1) begin
                f_data[2*j] = gen; f_data[2*j+1] = chf;
            end else begin
                f_data[2*j] = chf; f_data[2*j+1] = gen;
            end
        end
    endtask

    // Winnower model computed at frame level.
    task automatic model_frame(output logic [31:0] em, output logic [15:0] ec,
                               output logic [2:0] ee);
        logic te, ce, se, ma, mb;
        ec = f_data[0][15:0]; te = 1'b0; ce = 1'b0; em = '0;
        for (int j = 0; j < 32; j++) begin
            ma = (f_data[2*j][31:16]   == cache[j]);
            mb = (f_data[2*j+1][31:16] == cache[j]);
            if (ma != mb) em[j] = ma ? f_data[2*j][32] : f_data[2*j+1][32];
            else te = 1'b1;
        end
        for (int i = 0; i < 64; i++) if (f_data[i][15:0] != ec) ce = 1'b1;
        se = m_have_last && (ec != 16'(m_last_ctr + 16'd1));
        if (!te && !ce) begin m_have_last = 1'b1; m_last_ctr = ec; end
        ee = {se, ce, te};
    endtask

    task automatic send_pkt(input logic [32:0] d, input logic s);
        int g = 0;
        pkt_data = d; pkt_sof = s; pkt_valid = 1'b1;
        while (!pkt_ready && g < 100) begin @(posedge clk); #1; g++; end
        @(posedge clk); #1;
        pkt_valid = 1'b0; pkt_sof = 1'b0;
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) send_pkt(f_data[i], i == 0);
    endtask

    task automatic take_msg(output logic [31:0] m, output logic [15:0] c,
                            output logic [2:0] e, output bit to);
        int g = 0;
        to = 1'b0;
        while (!msg_valid && g < 200) begin @(posedge clk); #1; g++; end
        if (!msg_valid) begin to = 1'b1; m = '0; c = '0; e = '0; return; end
        m = msg_out; c = msg_ctr; e = msg_err;
        msg_ready = 1'b1;
        @(posedge clk); #1;
        msg_ready = 1'b0;
    endtask

    task automatic run_frame(output logic [31:0] m, output logic [15:0] c,
                             output logic [2:0] e, output bit to);
        send_frame(64);
        take_msg(m, c, e, to);
    endtask

    task automatic test_reset;
        n_cmp++; if (msg_valid !== 1'b0) begin n_fail++; $display("FAIL reset msg_valid: got %b want 0", msg_valid); end
        n_cmp++; if (msg_out !== 32'h0) begin n_fail++; $display("FAIL reset msg_out: got %h want 0", msg_out); end
        n_cmp++; if (msg_ctr !== 16'h0) begin n_fail++; $display("FAIL reset msg_ctr: got %h want 0", msg_ctr); end
        n_cmp++; if (msg_err !== 3'b0) begin n_fail++; $display("FAIL reset msg_err: got %b want 000", msg_err); end
        n_cmp++; if (resync_cnt !== 8'd0) begin n_fail++; $display("FAIL reset resync_cnt: got %0d want 0", resync_cnt); end
        n_cmp++; if (pkt_ready !== 1'b1) begin n_fail++; $display("FAIL reset pkt_ready: got %b want 1", pkt_ready); end
    endtask

    task automatic test_clean;
        logic [31:0] gm, em; logic [15:0] gc, ec; logic [2:0] ge, ee; bit to;
        build_frame(32'hA5A5_3C3C, 16'h0010);
        model_frame(em, ec, ee);
        send_frame(63);
        n_cmp++; if (msg_valid !== 1'b0) begin n_fail++; $display("FAIL clean early valid: got %b want 0", msg_valid); end
        send_pkt(f_data[63], 1'b0);
        n_cmp++; if (msg_valid !== 1'b1) begin n_fail++; $display("FAIL clean latency: msg_valid got %b want 1", msg_valid); end
        take_msg(gm, gc, ge, to);
        n_cmp++; if (to || gm !== 32'hA5A5_3C3C) begin n_fail++; $display("FAIL clean msg_out: got %h want a5a53c3c", gm); end
        n_cmp++; if (gc !== 16'h0010 || gc !== ec) begin n_fail++; $display("FAIL clean msg_ctr: got %h want %h", gc, ec); end
        n_cmp++; if (ge !== ee) begin n_fail++; $display("FAIL clean msg_err: got %b want %b", ge, ee); end
        n_cmp++; if (msg_valid !== 1'b0 || pkt_ready !== 1'b1) begin n_fail++; $display("FAIL clean return: valid %b ready %b want 0 1", msg_valid, pkt_ready); end
    endtask

    task automatic test_sequence;
        logic [31:0] gm, em; logic [15:0] gc, ec; logic [2:0] ge, ee; bit to;
        logic [15:0] ctrs [0:2];
        ctrs[0] = 16'h0012; ctrs[1] = 16'hFFFF; ctrs[2] = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            build_frame(32'($urandom), ctrs[k]);
            model_frame(em, ec, ee);
            run_frame(gm, gc, ge, to);
            n_cmp++; if (to || {gm, gc} !== {em, ec}) begin n_fail++; $display("FAIL seq[%0d] msg/ctr: got %h/%h want %h/%h", k, gm, gc, em, ec); end
            n_cmp++; if (ge !== ee) begin n_fail++; $display("FAIL seq[%0d] msg_err: got %b want %b", k, ge, ee); end
        end
    endtask

    task automatic test_tag_collision;
        logic [31:0] gm, em; logic [15:0] gc, ec; logic [2:0] ge, ee; bit to;
        logic [15:0] saved;
        saved = cache[28];
        cache[28] = cache[3];
        build_frame(32'hFFFF_FFFF, 16'(m_last_ctr + 16'd1));
        if (f_data[6][31:16] == cache[3]) f_data[7][31:16] = cache[28];
        else f_data[6][31:16] = cache[28];
        model_frame(em, ec, ee);
        run_frame(gm, gc, ge, to);
        cache[28] = saved;
        n_cmp++; if (to || gm[3] !== 1'b0 || gm !== em) begin n_fail++; $display("FAIL collision msg_out: got %h want %h", gm, em); end
        n_cmp++; if (ge[0] !== 1'b1 || ge !== ee) begin n_fail++; $display("FAIL collision msg_err: got %b want %b", ge, ee); end
        build_frame(32'($urandom), 16'(m_last_ctr + 16'd2));
        model_frame(em, ec, ee);
        run_frame(gm, gc, ge, to);
        n_cmp++; if (to || ge !== ee) begin n_fail++; $display("FAIL collision no-update msg_err: got %b want %b", ge, ee); end
    endtask

    task automatic test_ctr_corrupt;
        logic [31:0] gm, em; logic [15:0] gc, ec; logic [2:0] ge, ee; bit to;
        build_frame(32'($urandom), 16'h0010);
        f_data[17][15:0] = 16'h0011;
        model_frame(em, ec, ee);
        run_frame(gm, gc, ge, to);
        n_cmp++; if (to || ge[1] !== 1'b1 || ge !== ee) begin n_fail++; $display("FAIL ctr msg_err: got %b want %b", ge, ee); end
        n_cmp++; if (gc !== 16'h0010 || gm !== em) begin n_fail++; $display("FAIL ctr msg: got %h/%h want %h/0010", gm, gc, em); end
    endtask

    task automatic test_framing;
        logic [31:0] gm, em; logic [15:0] gc, ec; logic [2:0] ge, ee; bit to;
        for (int i = 0; i < 3; i++) send_pkt(33'($urandom), 1'b0);
        n_cmp++; if (resync_cnt !== 8'(m_resync)) begin n_fail++; $display("FAIL drop resync_cnt: got %0d want %0d", resync_cnt, m_resync); end
        build_frame(32'($urandom), 16'h7777);
        send_frame(20);
        build_frame(32'($urandom), 16'(m_last_ctr + 16'd1));
        model_frame(em, ec, ee);
        run_frame(gm, gc, ge, to);
        m_resync = 1;
        n_cmp++; if (resync_cnt !== 8'(m_resync)) begin n_fail++; $display("FAIL sof resync_cnt: got %0d want %0d", resync_cnt, m_resync); end
        n_cmp++; if (to || {gm, gc, ge} !== {em, ec, ee}) begin n_fail++; $display("FAIL sof frame: got %h/%h/%b want %h/%h/%b", gm, gc, ge, em, ec, ee); end
        for (int i = 0; i < 301; i++) send_pkt(33'($urandom), 1'b1);
        m_resync = (m_resync + 300 > 255) ? 255 : m_resync + 300;
        n_cmp++; if (resync_cnt !== 8'(m_resync)) begin n_fail++; $display("FAIL sat resync_cnt: got %0d want %0d", resync_cnt, m_resync); end
        build_frame(32'($urandom), 16'(m_last_ctr + 16'd1));
        model_frame(em, ec, ee);
        run_frame(gm, gc, ge, to);
        n_cmp++; if (resync_cnt !== 8'd255) begin n_fail++; $display("FAIL sat hold resync_cnt: got %0d want 255", resync_cnt); end
        n_cmp++; if (to || {gm, gc, ge} !== {em, ec, ee}) begin n_fail++; $display("FAIL sat frame: got %h/%h/%b want %h/%h/%b", gm, gc, ge, em, ec, ee); end
    endtask

    task automatic test_backpressure;
        logic [31:0] gm, em; logic [15:0] gc, ec; logic [2:0] ge, ee; bit to;
        logic [50:0] held;
        build_frame(32'($urandom), 16'(m_last_ctr + 16'd1));
        model_frame(em, ec, ee);
        send_frame(64);
        held = {msg_out, msg_ctr, msg_err};
        pkt_data = 33'($urandom); pkt_sof = 1'b1; pkt_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({msg_out, msg_ctr, msg_err} !== held || msg_valid !== 1'b1 || pkt_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold cyc%0d: out %h valid %b ready %b want %h 1 0", c, {msg_out, msg_ctr, msg_err}, msg_valid, pkt_ready, held);
            end
        end
        take_msg(gm, gc, ge, to);
        pkt_valid = 1'b0; pkt_sof = 1'b0;
        n_cmp++; if (to || {gm, gc, ge} !== {em, ec, ee}) begin n_fail++; $display("FAIL hold frame: got %h/%h/%b want %h/%h/%b", gm, gc, ge, em, ec, ee); end
        build_frame(32'($urandom), 16'(m_last_ctr + 16'd1));
        model_frame(em, ec, ee);
        run_frame(gm, gc, ge, to);
        n_cmp++; if (resync_cnt !== 8'(m_resync) || to || {gm, gc, ge} !== {em, ec, ee}) begin
            n_fail++; $display("FAIL after-handshake: resync %0d msg %h/%h/%b want %0d %h/%h/%b", resync_cnt, gm, gc, ge, m_resync, em, ec, ee);
        end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] gm, em; logic [15:0] gc, ec; logic [2:0] ge, ee; bit to;
        build_frame(32'hFFFF_FFFF, 16'(m_last_ctr + 16'd1));
        send_frame(30);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_have_last = 1'b0; m_last_ctr = '0; m_resync = 0;
        n_cmp++;
        if ({msg_valid, msg_out, msg_ctr, msg_err, resync_cnt} !== '0 || pkt_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset outputs: valid %b out %h ctr %h err %b resync %0d ready %b want all 0, ready 1",
                               msg_valid, msg_out, msg_ctr, msg_err, resync_cnt, pkt_ready);
        end
        build_frame(32'($urandom), 16'h0500);
        model_frame(em, ec, ee);
        run_frame(gm, gc, ge, to);
        n_cmp++; if (to || ge !== 3'b000 || {gm, gc, ge} !== {em, ec, ee}) begin n_fail++; $display("FAIL post-reset frame: got %h/%h/%b want %h/%h/000", gm, gc, ge, em, ec); end
    endtask

    task automatic test_random;
        logic [31:0] gm, em; logic [15:0] gc, ec; logic [2:0] ge, ee; bit to;
        int p, j;
        for (int k = 0; k < 8; k++) begin
            build_frame(32'($urandom),
                        ($urandom_range(0, 3) != 0) ? 16'(m_last_ctr + 16'd1) : 16'($urandom));
            case ($urandom_range(0, 3))
                0: begin p = $urandom_range(1, 63); f_data[p][15:0] = ~f_data[p][15:0]; end
                1: begin j = $urandom_range(0, 31); f_data[2*j][31:16] = cache[j]; f_data[2*j+1][31:16] = cache[j]; end
                2: begin j = $urandom_range(0, 31); f_data[2*j][31:16] = ~cache[j]; f_data[2*j+1][31:16] = ~cache[j]; end
                default: ;
            endcase
            model_frame(em, ec, ee);
            run_frame(gm, gc, ge, to);
            n_cmp++; if (to || {gm, gc, ge} !== {em, ec, ee}) begin n_fail++; $display("FAIL random[%0d]: got %h/%h/%b want %h/%h/%b", k, gm, gc, ge, em, ec, ee); end
        end
    endtask

    initial begin
        rst = 1'b1; pkt_valid = 1'b0; pkt_sof = 1'b0; pkt_data = '0; msg_ready = 1'b0;
        for (int i = 0; i < 64; i++) cache[i] = 16'($urandom);
        m_have_last = 1'b0; m_last_ctr = '0; m_resync = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset;
        test_clean;
        test_sequence;
        test_tag_collision;
        test_ctr_corrupt;
        test_framing;
        test_backpressure;
        test_reset_midframe;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
